fwd_pass_sequencer: RTL and testbench

- Controller that runs one complete forward pass of the forward engine (nonlinear layer, then linear layer, then error accumulator) for one vector of unknowns.
- Clears the engine and streams the NUM_UNKNOWNS guesses plus the bias word serially into the engine's scalar input.
- Waits out the pipeline, then captures the NUM_UNKNOWNS f_i(X) results and the accumulated squared error.
- Sits between the trainer (requester) and the forward engine.

---
 rtl/fwd_pass_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_fwd_pass_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_pass_sequencer.sv
// ---------------------------------------------------------------------------
// fwd_pass_sequencer
//
// Runs one complete forward pass of the forward engine (nonlinear layer,
// linear layer, error accumulator) for one vector of unknowns:
//   CLEAR   : one cycle of engine clear
//   LOAD    : NUM_UNKNOWNS guesses then the bias word 1.0, one word per cycle
//   DRAIN   : PIPE_LAT idle cycles while the engine pipeline fills
//   COLLECT : NUM_UNKNOWNS cycles, each presenting one f_i(X) result
//   ERR     : the accumulated squared error is captured
//   FINISH  : one-cycle DONE pulse, back to IDLE
// ABORT in any non-IDLE state gives one engine-clear cycle, then IDLE.
//
// Ports
//   CLK                   system clock, rising edge
//   RESET                 asynchronous active-low reset
//   START                 pass request, accepted only in IDLE
//   ABORT                 cancel the pass in progress
//   X_IN                  guesses, element 0 in the LSBs, latched on START
//   BUSY                  high in every state except IDLE
//   DONE                  one-cycle pulse when a pass completes
//   ENG_RESET             active-high clear to the engine
//   ENG_INITIAL_READ_FLAG first-word marker to the engine
//   ENG_INPUT_SCALER      serial input word to the engine
//   ENG_ACC_RESULT        engine per-equation output
//   ENG_ERROR_ACC_OUT     engine accumulated error
//   F_VALID / F_IDX / F_DATA  one f_i(X) result per cycle during COLLECT
//   ERROR_OUT             captured error of the last completed pass
//
// Every output is a register loaded from the next-state decode, so each
// output is valid for exactly the cycles its state occupies.
// ---------------------------------------------------------------------------
module fwd_pass_sequencer #(
    parameter int NUM_UNKNOWNS = 2,
    parameter int BIT_WIDTH    = 32,
    parameter int EXTRA_BITS   = 2,
    parameter int PIPE_LAT     = 4,
    parameter int CNT_W        = 8
) (
    input  logic                                          CLK,
    input  logic                                          RESET,
    input  logic                                          START,
    input  logic                                          ABORT,
    input  logic [NUM_UNKNOWNS*(BIT_WIDTH+EXTRA_BITS)-1:0] X_IN,
    output logic                                          BUSY,
    output logic                                          DONE,
    output logic                                          ENG_RESET,
    output logic                                          ENG_INITIAL_READ_FLAG,
    output logic [BIT_WIDTH+EXTRA_BITS-1:0]               ENG_INPUT_SCALER,
    input  logic [BIT_WIDTH+EXTRA_BITS-1:0]               ENG_ACC_RESULT,
    input  logic [BIT_WIDTH+EXTRA_BITS-1:0]               ENG_ERROR_ACC_OUT,
    output logic                                          F_VALID,
    output logic [CNT_W-1:0]                              F_IDX,
    output logic [BIT_WIDTH+EXTRA_BITS-1:0]               F_DATA,
    output logic [BIT_WIDTH+EXTRA_BITS-1:0]               ERROR_OUT
);

    localparam int WORD_W = BIT_WIDTH + EXTRA_BITS;

    // Bias 1.0: sign 0, exponent 0x7F, mantissa 0; the exception field
    // (when present) is 2'b01 = "normal number". With EXTRA_BITS = 0 the
    // shifted-out one disappears and only the IEEE word remains.
    localparam logic [BIT_WIDTH-1:0] BIAS_CORE = {1'b0, 8'h7F, {(BIT_WIDTH-9){1'b0}}};
    localparam logic [WORD_W-1:0]    BIAS_WORD = (WORD_W'(1) << BIT_WIDTH) | WORD_W'(BIAS_CORE);

    // State encoding kept as plain constants for compatibility with older tools.
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_DRAIN   = 3'd3;
    localparam logic [2:0] S_COLLECT = 3'd4;
    localparam logic [2:0] S_ERR     = 3'd5;
    localparam logic [2:0] S_FINISH  = 3'd6;
    localparam logic [2:0] S_ABORT   = 3'd7;   // clear-then-idle after ABORT

    // Last count value of each multi-cycle state; the counter restarts at 0
    // on every state entry, so it never wraps.
    localparam logic [CNT_W-1:0] LOAD_LAST    = CNT_W'(NUM_UNKNOWNS);
    localparam logic [CNT_W-1:0] DRAIN_LAST   = CNT_W'(PIPE_LAT - 1);
    localparam logic [CNT_W-1:0] COLLECT_LAST = CNT_W'(NUM_UNKNOWNS - 1);

    logic [2:0]       state;
    logic [2:0]       nxt_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] nxt_cnt;

    logic [NUM_UNKNOWNS-1:0][WORD_W-1:0] x_lat;
    logic [WORD_W-1:0]                   load_word;

    // -----------------------------------------------------------------------
    // Next-state and counter decode
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: defaults first, so every path through the block assigns both
        // signals and no latch is inferred.
        nxt_state = state;
        nxt_cnt   = cnt;

        if (state == S_IDLE) begin
            // START beats a simultaneous ABORT here: ABORT means nothing in IDLE.
            if (START) begin
                nxt_state = S_CLEAR;
                nxt_cnt   = '0;
            end
        end else if (ABORT) begin
            nxt_state = S_ABORT;
            nxt_cnt   = '0;
        end else begin
            case (state)
                S_CLEAR: begin
                    nxt_state = S_LOAD;
                    nxt_cnt   = '0;
                end
                S_LOAD: begin
                    if (cnt == LOAD_LAST) begin
                        nxt_state = S_DRAIN;
                        nxt_cnt   = '0;
                    end else begin
                        nxt_cnt = cnt + CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        nxt_state = S_COLLECT;
                        nxt_cnt   = '0;
                    end else begin
                        nxt_cnt = cnt + CNT_W'(1);
                    end
                end
                S_COLLECT: begin
                    if (cnt == COLLECT_LAST) begin
                        nxt_state = S_ERR;
                        nxt_cnt   = '0;
                    end else begin
                        nxt_cnt = cnt + CNT_W'(1);
                    end
                end
                S_ERR: begin
                    nxt_state = S_FINISH;
                end
                S_FINISH, S_ABORT: begin
                    nxt_state = S_IDLE;
                    nxt_cnt   = '0;
                end
                default: begin
                    nxt_state = S_IDLE;
                    nxt_cnt   = '0;
                end
            endcase
        end
    end

    // Word streamed on load count nxt_cnt: latched guess k, or the bias once
    // the count passes the last guess.
    always_comb begin
        load_word = BIAS_WORD;
        for (int i = 0; i < NUM_UNKNOWNS; i++) begin
            if (nxt_cnt == CNT_W'(i)) begin
                load_word = x_lat[i];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Guess latch
    // -----------------------------------------------------------------------
    // NOTE: x_lat is deliberately not reset: it is always written when a
    // pass is accepted and is only read during that pass's LOAD state.
    always_ff @(posedge CLK) begin
        if (state == S_IDLE && START) begin
            x_lat <= X_IN;
        end
    end

    // -----------------------------------------------------------------------
    // State, counter and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state                 <= S_IDLE;
            cnt                   <= '0;
            BUSY                  <= 1'b0;
            DONE                  <= 1'b0;
            ENG_RESET             <= 1'b1;   // engine held clear while in reset
            ENG_INITIAL_READ_FLAG <= 1'b0;
            ENG_INPUT_SCALER      <= '0;
            F_VALID               <= 1'b0;
            F_IDX                 <= '0;
            F_DATA                <= '0;
            ERROR_OUT             <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here updates from the pre-edge values and ordering is irrelevant.
            state                 <= nxt_state;
            cnt                   <= nxt_cnt;
            BUSY                  <= (nxt_state != S_IDLE);
            DONE                  <= (nxt_state == S_FINISH);
            ENG_RESET             <= (nxt_state == S_CLEAR) || (nxt_state == S_ABORT);
            ENG_INITIAL_READ_FLAG <= (nxt_state == S_LOAD) && (nxt_cnt == '0);
            ENG_INPUT_SCALER      <= (nxt_state == S_LOAD) ? load_word : '0;
            F_VALID               <= (nxt_state == S_COLLECT);
            F_IDX                 <= (nxt_state == S_COLLECT) ? nxt_cnt : '0;
            // The engine result seen in the cycle before each COLLECT cycle.
            F_DATA                <= (nxt_state == S_COLLECT) ? ENG_ACC_RESULT : '0;
            // Only a pass that reaches FINISH updates the error; an ABORT in
            // ERR leaves the previous value in place.
            if (state == S_ERR && nxt_state == S_FINISH) begin
                ERROR_OUT <= ENG_ERROR_ACC_OUT;
            end
        end
    end

endmodule

// File: tb/tb_fwd_pass_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fwd_pass_sequencer
//
// Two instances share clock and reset: u0 with NUM_UNKNOWNS=2, PIPE_LAT=4
// and u1 with NUM_UNKNOWNS=4, PIPE_LAT=1. A behavioural model tracks each
// pass as an offset t from the START cycle (t=1 clear, t=2..2+N load, ...,
// t=4+2N+P done) and a compare process checks every output against it on
// every falling edge. Directed scenarios add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_fwd_pass_sequencer;

    localparam int W  = 34;
    localparam int CW = 8;
    localparam int XW = 4 * W;

    localparam logic [W-1:0] BIAS = 34'h1_3F80_0000;   // {01, 0, 0x7F, 0}
    localparam logic [W-1:0] F2_0 = 34'h1_4000_0000;   // 2.0
    localparam logic [W-1:0] F3_0 = 34'h1_4040_0000;   // 3.0

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    logic          start_s   [2];
    logic          abort_s   [2];
    logic [XW-1:0] x_in_s    [2];
    logic [W-1:0]  acc_s     [2];
    logic [W-1:0]  err_s     [2];

    logic          busy_o    [2];
    logic          done_o    [2];
    logic          eng_rst_o [2];
    logic          init_o    [2];
    logic [W-1:0]  sc_o      [2];
    logic          fv_o      [2];
    logic [CW-1:0] fidx_o    [2];
    logic [W-1:0]  fdata_o   [2];
    logic [W-1:0]  errout_o  [2];

    fwd_pass_sequencer #(
        .NUM_UNKNOWNS(2), .BIT_WIDTH(32), .EXTRA_BITS(2), .PIPE_LAT(4), .CNT_W(CW)
    ) u0 (
        .CLK(CLK), .RESET(RESET), .START(start_s[0]), .ABORT(abort_s[0]),
        .X_IN(x_in_s[0][2*W-1:0]), .BUSY(busy_o[0]), .DONE(done_o[0]),
        .ENG_RESET(eng_rst_o[0]), .ENG_INITIAL_READ_FLAG(init_o[0]),
        .ENG_INPUT_SCALER(sc_o[0]), .ENG_ACC_RESULT(acc_s[0]),
        .ENG_ERROR_ACC_OUT(err_s[0]), .F_VALID(fv_o[0]), .F_IDX(fidx_o[0]),
        .F_DATA(fdata_o[0]), .ERROR_OUT(errout_o[0])
    );

    fwd_pass_sequencer #(
        .NUM_UNKNOWNS(4), .BIT_WIDTH(32), .EXTRA_BITS(2), .PIPE_LAT(1), .CNT_W(CW)
    ) u1 (
        .CLK(CLK), .RESET(RESET), .START(start_s[1]), .ABORT(abort_s[1]),
        .X_IN(x_in_s[1]), .BUSY(busy_o[1]), .DONE(done_o[1]),
        .ENG_RESET(eng_rst_o[1]), .ENG_INITIAL_READ_FLAG(init_o[1]),
        .ENG_INPUT_SCALER(sc_o[1]), .ENG_ACC_RESULT(acc_s[1]),
        .ENG_ERROR_ACC_OUT(err_s[1]), .F_VALID(fv_o[1]), .F_IDX(fidx_o[1]),
        .F_DATA(fdata_o[1]), .ERROR_OUT(errout_o[1])
    );

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;
    bit eng_rand = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           mt       [2];      // offset within the pass, 0 = idle
    bit           ab       [2];      // in the clear cycle that follows ABORT
    bit           post_rst;          // reset released, no clock edge seen yet
    logic [W-1:0] xl       [2][4];
    logic [W-1:0] prev_acc [2];
    logic [W-1:0] err_m    [2];

    function automatic int nu(input int d); return (d == 0) ? 2 : 4; endfunction
    function automatic int pl(input int d); return (d == 0) ? 4 : 1; endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            mt[d] = 0; ab[d] = 1'b0; err_m[d] = '0; prev_acc[d] = '0;
        end
        post_rst = 1'b1;
    endtask

    task automatic model_step(input int d);
        int n, p, l;
        n = nu(d); p = pl(d); l = 4 + 2*n + p;
        if (ab[d]) begin
            ab[d] = abort_s[d];
        end else if (mt[d] == 0) begin
            if (start_s[d]) begin
                mt[d] = 1;
                for (int k = 0; k < n; k++) xl[d][k] = x_in_s[d][k*W +: W];
            end
        end else if (abort_s[d]) begin
            mt[d] = 0; ab[d] = 1'b1;
        end else begin
            if (mt[d] == l - 1) err_m[d] = err_s[d];
            mt[d] = (mt[d] == l) ? 0 : mt[d] + 1;
        end
        prev_acc[d] = acc_s[d];
    endtask

    function automatic logic [W-1:0] rnd_word();
        return W'({$urandom, $urandom});
    endfunction

    function automatic logic [XW-1:0] rnd_x();
        return XW'({$urandom, $urandom, $urandom, $urandom, $urandom});
    endfunction

    // Advance to the next cycle: the model sees the inputs that were present
    // at the edge, then new engine data is driven.
    task automatic next_cycle();
        @(posedge CLK);
        if (!RESET) model_reset();
        else begin
            post_rst = 1'b0;
            for (int d = 0; d < 2; d++) model_step(d);
        end
        #1;
        if (eng_rand) begin
            for (int d = 0; d < 2; d++) begin
                acc_s[d] = rnd_word();
                err_s[d] = rnd_word();
            end
        end
    endtask

    // ---------------- compare process ----------------
    task automatic compare_dut(input int d);
        int n, p, l, t, k, j;
        logic ld, coll;
        logic [W-1:0] e_sc, e_fd;
        n = nu(d); p = pl(d); l = 4 + 2*n + p; t = mt[d];
        k = t - 2;
        ld = (t >= 2) && (t <= 2 + n);
        j = t - (3 + n + p);
        coll = (t >= 3 + n + p) && (t <= 2 + 2*n + p);
        e_sc = '0;
        if (ld) e_sc = (k == n) ? BIAS : xl[d][k];
        e_fd = coll ? prev_acc[d] : '0;
        check($sformatf("u%0d.busy", d),    busy_o[d],    (t != 0) || ab[d]);
        check($sformatf("u%0d.done", d),    done_o[d],    t == l);
        check($sformatf("u%0d.eng_rst", d), eng_rst_o[d], (t == 1) || ab[d] || post_rst);
        check($sformatf("u%0d.init", d),    init_o[d],    ld && (k == 0));
        check($sformatf("u%0d.scaler", d),  sc_o[d],      e_sc);
        check($sformatf("u%0d.f_valid", d), fv_o[d],      coll);
        check($sformatf("u%0d.f_idx", d),   fidx_o[d],    coll ? j : 0);
        check($sformatf("u%0d.f_data", d),  fdata_o[d],   e_fd);
        check($sformatf("u%0d.err_out", d), errout_o[d],  err_m[d]);
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) compare_dut(d);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0]  dmask, fmask;
        int           dcnt;
        logic [W-1:0] xv [4];

        for (int d = 0; d < 2; d++) begin
            start_s[d] = 1'b0; abort_s[d] = 1'b0; x_in_s[d] = '0;
            acc_s[d] = '0; err_s[d] = '0;
        end
        model_reset();

        // Reset and release
        #2 RESET = 1'b0;
        model_reset();
        chk_en = 1'b1;
        #1;
        check("rst.busy", busy_o[0], 1'b0);
        check("rst.eng_reset", eng_rst_o[0], 1'b1);
        check("rst.error_out", errout_o[0], '0);
        repeat (3) begin next_cycle(); @(negedge CLK); end
        next_cycle();
        RESET = 1'b1;
        @(negedge CLK);
        check("rel.eng_reset_held", eng_rst_o[0], 1'b1);
        next_cycle(); @(negedge CLK);
        check("rel.eng_reset_low", eng_rst_o[0], 1'b0);

        // Directed single pass on u0, with a START pulse while busy and an
        // X_IN change after acceptance
        err_s[0] = 34'hC;
        dcnt = 0; fmask = '0;
        for (int c = 0; c <= 14; c++) begin
            next_cycle();
            start_s[0] = (c == 0) || (c == 6);
            x_in_s[0]  = (c == 0) ? XW'({F3_0, F2_0}) : rnd_x();
            acc_s[0]   = (c == 8) ? 34'hA : (c == 9) ? 34'hB : '0;
            @(negedge CLK);
            if (done_o[0]) dcnt++;
            if (fv_o[0]) fmask[c] = 1'b1;
            case (c)
                1: begin check("dir.c1_eng_reset", eng_rst_o[0], 1'b1);
                         check("dir.c1_busy", busy_o[0], 1'b1); end
                2: begin check("dir.c2_x0", sc_o[0], F2_0);
                         check("dir.c2_init", init_o[0], 1'b1); end
                3: begin check("dir.c3_x1", sc_o[0], F3_0);
                         check("dir.c3_init", init_o[0], 1'b0); end
                4: check("dir.c4_bias", sc_o[0], BIAS);
                9: begin check("dir.c9_idx", fidx_o[0], 0);
                         check("dir.c9_data", fdata_o[0], 34'hA); end
                10: begin check("dir.c10_idx", fidx_o[0], 1);
                          check("dir.c10_data", fdata_o[0], 34'hB); end
                11: check("dir.c11_err_old", errout_o[0], '0);
                12: begin check("dir.c12_done", done_o[0], 1'b1);
                          check("dir.c12_err", errout_o[0], 34'hC); end
                13: check("dir.c13_busy", busy_o[0], 1'b0);
                default: ;
            endcase
        end
        start_s[0] = 1'b0;
        check("dir.done_count", dcnt, 1);
        check("dir.fvalid_cycles", fmask, 32'h0000_0600);

        // ABORT in cycle 9
        err_s[0] = 34'hD;
        dcnt = 0; fmask = '0;
        for (int c = 0; c <= 14; c++) begin
            next_cycle();
            start_s[0] = (c == 0);
            abort_s[0] = (c == 9);
            x_in_s[0]  = rnd_x();
            acc_s[0]   = (c == 8) ? 34'h5 : '0;
            @(negedge CLK);
            if (done_o[0]) dcnt++;
            if (fv_o[0]) fmask[c] = 1'b1;
            case (c)
                10: begin check("abt.c10_eng_reset", eng_rst_o[0], 1'b1);
                          check("abt.c10_busy", busy_o[0], 1'b1); end
                11: begin check("abt.c11_busy", busy_o[0], 1'b0);
                          check("abt.c11_eng_reset", eng_rst_o[0], 1'b0); end
                14: check("abt.err_held", errout_o[0], 34'hC);
                default: ;
            endcase
        end
        abort_s[0] = 1'b0;
        check("abt.done_count", dcnt, 0);
        check("abt.fvalid_cycles", fmask, 32'h0000_0200);

        // Back-to-back with START held high
        dmask = '0;
        for (int c = 0; c <= 30; c++) begin
            next_cycle();
            start_s[0] = (c <= 13);
            x_in_s[0]  = rnd_x();
            @(negedge CLK);
            if (done_o[0]) dmask[c] = 1'b1;
            if (c == 13) check("b2b.c13_idle", busy_o[0], 1'b0);
            if (c == 14) check("b2b.c14_clear", eng_rst_o[0], 1'b1);
        end
        start_s[0] = 1'b0;
        check("b2b.done_cycles", dmask, 32'h0200_1000);

        // Parameter sweep: u1 with N=4, P=1
        for (int k = 0; k < 4; k++) xv[k] = rnd_word();
        dmask = '0; fmask = '0;
        for (int c = 0; c <= 16; c++) begin
            next_cycle();
            start_s[1] = (c == 0);
            x_in_s[1]  = (c == 0) ? {xv[3], xv[2], xv[1], xv[0]} : rnd_x();
            @(negedge CLK);
            if (done_o[1]) dmask[c] = 1'b1;
            if (fv_o[1]) fmask[c] = 1'b1;
            if (c >= 2 && c <= 5) check($sformatf("swp.c%0d_x", c), sc_o[1], xv[c-2]);
            if (c == 2) check("swp.c2_init", init_o[1], 1'b1);
            if (c == 6) check("swp.c6_bias", sc_o[1], BIAS);
            if (c == 7) check("swp.c7_drain", sc_o[1], '0);
        end
        start_s[1] = 1'b0;
        check("swp.done_cycles", dmask, 32'h0000_2000);
        check("swp.fvalid_cycles", fmask, 32'h0000_0F00);

        // Reset dropped mid-pass, during DRAIN of u0
        for (int c = 0; c <= 6; c++) begin
            next_cycle();
            start_s[0] = (c == 0);
            x_in_s[0]  = rnd_x();
            @(negedge CLK);
        end
        start_s[0] = 1'b0;
        #2 RESET = 1'b0;
        model_reset();
        #1;
        check("mrst.busy", busy_o[0], 1'b0);
        check("mrst.eng_reset", eng_rst_o[0], 1'b1);
        check("mrst.done", done_o[0], 1'b0);
        check("mrst.scaler", sc_o[0], '0);
        check("mrst.error_out", errout_o[0], '0);
        next_cycle();
        RESET = 1'b1;
        @(negedge CLK);
        check("mrst.eng_reset_held", eng_rst_o[0], 1'b1);
        dcnt = 0;
        for (int c = 0; c < 12; c++) begin
            next_cycle(); @(negedge CLK);
            if (done_o[0]) dcnt++;
        end
        check("mrst.no_done", dcnt, 0);

        // Randomised traffic on both instances
        eng_rand = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            next_cycle();
            for (int d = 0; d < 2; d++) begin
                start_s[d] = ($urandom_range(0, 2) == 0);
                abort_s[d] = ($urandom_range(0, 24) == 0);
                x_in_s[d]  = rnd_x();
            end
            @(negedge CLK);
        end
        for (int d = 0; d < 2; d++) begin start_s[d] = 1'b0; abort_s[d] = 1'b0; end
        repeat (20) begin next_cycle(); @(negedge CLK); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
